// File: rtl/seq_match_counter.sv
// seq_match_counter: windowed count of detector match pulses with valid/ready report and threshold alarm
// clk/rst: rising-edge clock, asynchronous active-low reset
// en: start/continue windows (low aborts a window), det: one-cycle match flag
// window_len: cycles per window (0 = 2^WIN_W), threshold: alarm level (0 = off)
// rpt_valid/rpt_ready/rpt_count/rpt_overflow: per-window report handshake
// alarm: in-window count reached threshold, busy: counting or reporting
module seq_match_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             det,
  input  logic [WIN_W-1:0] window_len,
  input  logic [CNT_W-1:0] threshold,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
  output logic             rpt_overflow,
  output logic             alarm,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, COUNT, REPORT} state_t;
  state_t state, state_n;
  logic [WIN_W-1:0] win_q, wcnt;
  logic [CNT_W-1:0] thr_q, mcnt, mcnt_n;
  logic ovf, ovf_n, start, last, hit;
  // window_len 0 wraps to all-ones here, giving a 2^WIN_W cycle window
  assign last   = wcnt == win_q - WIN_W'(1);
  assign mcnt_n = (det && !(&mcnt)) ? mcnt + CNT_W'(1) : mcnt;
  assign ovf_n  = ovf | (det & (&mcnt));
  assign hit    = thr_q != '0 && mcnt_n >= thr_q;
  always_comb begin
    state_n = state;
    start   = 1'b0;
    case (state)
      IDLE: begin
        state_n = en ? COUNT : IDLE;
        start   = en;
      end
      COUNT: state_n = !en ? IDLE : last ? REPORT : COUNT;
      REPORT: begin
        state_n = rpt_ready ? (en ? COUNT : IDLE) : REPORT;
        start   = rpt_ready & en;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // report flags are registered from the next state so every output comes from a flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {win_q, wcnt, thr_q, mcnt, ovf, alarm} <= '0;
      {rpt_valid, rpt_count, rpt_overflow, busy} <= '0;
    end else begin
      rpt_valid <= state_n == REPORT;
      busy      <= state_n != IDLE;
      if (start) begin
        win_q <= window_len;
        thr_q <= threshold;
        {wcnt, mcnt, ovf, alarm} <= '0;
      end else if (state == COUNT) begin
        if (!en) begin
          {wcnt, mcnt, ovf, alarm} <= '0;
        end else begin
          mcnt  <= mcnt_n;
          ovf   <= ovf_n;
          wcnt  <= wcnt + WIN_W'(1);
          alarm <= alarm | hit;
          if (last) begin
            rpt_count    <= mcnt_n;
            rpt_overflow <= ovf_n;
          end
        end
      end
    end
  end
endmodule

// File: doc/seq_match_counter.md
# seq_match_counter

Windowed event counter that consumes the one-cycle match flag from the Moore sequence detector. The flag is high for one cycle per detected pattern. The block counts matches over a programmable window of clock cycles and hands each window's result downstream through a valid/ready report port. It also raises an alarm level once the in-window count reaches a programmable threshold.

## Interface
- CNT_W, 8: width of the match counter and of `threshold` / `rpt_count`
- WIN_W, 16: width of the window-length counter and of `window_len`

- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- en  input  1  enable; high starts/continues windows, low aborts and idles
- det  input  1  match flag from the sequence detector (registered-state decode, glitch-free), sampled every cycle
- window_len  input  WIN_W  window length in cycles; 0 means 2^WIN_W cycles
- threshold  input  CNT_W  alarm threshold; 0 disables alarm
- rpt_valid  output  1  report available
- rpt_ready  input  1  downstream accepts report
- rpt_count  output  CNT_W  matches counted in the reported window (saturating)
- rpt_overflow  output  1  count saturated during the reported window
- alarm  output  1  in-window count has reached threshold
- busy  output  1  state is COUNT or REPORT

## Operation
- States: IDLE, COUNT, REPORT.
- IDLE:
  - On `en=1`, capture `window_len` into `win_q` and `threshold` into `thr_q`.
  - Clear `mcnt`, `wcnt`, `ovf` and alarm, then go to COUNT.
  - `det` is ignored.
- COUNT:
  - Every cycle: if `det=1`, `mcnt` increments, saturating at 2^CNT_W-1.
  - An increment attempted while `mcnt` is all-ones sets `ovf`, which is sticky for the window.
  - `wcnt` increments every cycle.
  - When `wcnt == win_q-1` (modulo 2^WIN_W), that cycle's `det` is still counted and the next state is REPORT.
  - `rpt_count`/`rpt_overflow` are loaded from the final `mcnt`/`ovf`, including the last cycle.
  - If `en=0` in any COUNT cycle, the window aborts: go to IDLE, no report, counters cleared, alarm cleared. That cycle's `det` is discarded.
- Alarm:
  - Set when `thr_q != 0` and the updated `mcnt >= thr_q`.
  - Stays high through REPORT.
  - Cleared when the next window starts, on abort, or on reset.
- REPORT:
  - `rpt_valid=1`; `rpt_count`/`rpt_overflow` are held stable until the handshake (`rpt_valid & rpt_ready`).
  - `det` is ignored.
  - On handshake with `en=1`: recapture `win_q`/`thr_q`, clear counters, go to COUNT. The first counted cycle is the one after the handshake.
  - On handshake with `en=0`: go to IDLE.
  - If `en=0` without a handshake, the block stays in REPORT; a pending report is never dropped.
- Reset (asserted at any time): state IDLE. `rpt_valid`, `rpt_count`, `rpt_overflow`, `alarm`, `busy`, all internal counters = 0.

## Timing
- Window = exactly `win_q` consecutive COUNT cycles; the first is the cycle after leaving IDLE/REPORT.
- `rpt_valid` rises 1 cycle after the last window cycle.
- Back-to-back windows with `rpt_ready` tied high lose one cycle (the REPORT cycle) between windows.
- `alarm` rises 1 cycle after the `det` sample that brings `mcnt` to `thr_q`.
- All outputs are registered; no combinational path from any input to any output.
- `rpt_ready` is only acted on while `rpt_valid=1`.

## Test plan
- Basic window:
  - Stimulus: `window_len=8`, `threshold=2`, `en=1`; `det` pulses on window cycles 2 and 6.
  - Required: `rpt_valid` high in the cycle after cycle 8, with `rpt_count=2` and `rpt_overflow=0`; `alarm` rises the cycle after the cycle-6 pulse.
- Backpressure:
  - Stimulus: hold `rpt_ready=0` for 5 cycles in REPORT while `det` pulses 3 times.
  - Required: `rpt_valid`/`rpt_count` stay constant; after `rpt_ready=1`, the next window counts only fresh pulses.
- Saturation:
  - Stimulus: CNT_W=8, `window_len=300`, `det` held 1.
  - Required: `rpt_count=255`, `rpt_overflow=1`.
- Abort:
  - Stimulus: drop `en` on window cycle 4 of 10.
  - Required: next cycle IDLE, `busy=0`, `alarm=0`, no `rpt_valid`.
  - Re-enable: new window with `mcnt=0`.
- Edge lengths:
  - `window_len=1`: a report every other cycle with `rpt_ready=1`; `rpt_count` equals `det` in each window cycle.
  - `window_len=0` with WIN_W=4: window is 16 cycles.
- Async reset:
  - Stimulus: assert `rst` low mid-REPORT, between clock edges.
  - Required: all outputs 0 immediately; after release with `en=1`, the first report matches a fresh window.
